// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: fetch PC, loadable instruction memory and a prefetch FIFO.
// Supports redirect with flush, sticky halt and debug-side program load while stopped.
module fetch_prefetch #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFFFFFF,
    localparam int unsigned AW = $clog2(MEM_DEPTH),
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [INSTR_W-1:0] i_wr_data,
    input  logic               i_pc_src,
    input  logic [PC_W-1:0]    i_pc_salto,
    input  logic               i_stall,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc_4,
    output logic               o_instr_valid,
    output logic               o_halt,
    output logic [PC_W-1:0]    o_pc,
    output logic [CW-1:0]      o_fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [INSTR_W-1:0] mem        [MEM_DEPTH];
    logic [INSTR_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [PC_W-1:0]    fifo_pc4   [FIFO_DEPTH];

    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic [CW:0]        occupancy;
    logic [PC_W-1:0]    fetch_pc, fetch_pc_4, resp_pc4;
    logic [INSTR_W-1:0] rd_data;
    logic               inflight, halt_seen, halt_done;
    logic               empty, resp_halt, head_halt;
    logic               req, push, pop;

    always_comb begin
        empty      = (count == '0);
        fetch_pc_4 = fetch_pc + PC_W'(4);
        occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
        // A halt word arriving this cycle already blocks the next request.
        resp_halt  = inflight && (rd_data == HALT_INSTR);
        head_halt  = !empty && (fifo_instr[rd_ptr] == HALT_INSTR);
        req  = i_valid && !halt_seen && !resp_halt && !i_pc_src &&
               (occupancy < (CW+1)'(FIFO_DEPTH));
        push = inflight && !i_pc_src;
        // The head is either a valid instruction or the halt word; both leave on !i_stall.
        pop  = !empty && !i_stall && !i_pc_src;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fetch_pc  <= '0;
            resp_pc4  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            halt_seen <= 1'b0;
            halt_done <= 1'b0;
        end else if (i_pc_src) begin
            fetch_pc <= i_pc_salto;
            if (!halt_done) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                inflight  <= 1'b0;
                halt_seen <= 1'b0;
            end
        end else begin
            inflight <= req;
            if (req) begin
                fetch_pc <= fetch_pc_4;
                resp_pc4 <= fetch_pc_4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (resp_halt)
                    halt_seen <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (head_halt)
                    halt_done <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage arrays carry no reset; loads and fetches never overlap since they key off i_valid.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_valid)
            mem[i_wr_addr] <= i_wr_data;
        if (req)
            rd_data <= mem[fetch_pc[AW+1:2]];
        if (push) begin
            fifo_instr[wr_ptr] <= rd_data;
            fifo_pc4[wr_ptr]   <= resp_pc4;
        end
    end

    assign o_instr       = empty ? '0 : fifo_instr[rd_ptr];
    assign o_pc_4        = empty ? '0 : fifo_pc4[rd_ptr];
    assign o_instr_valid = !empty && !head_halt && !halt_done;
    assign o_halt        = halt_done;
    assign o_pc          = fetch_pc;
    assign o_fifo_count  = count;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: cycle-accurate vector table plus a scoreboard for
// redirect, flushed-halt, wrap-around, write-guard and async-reset sequences.
module tb_fetch_prefetch;

    localparam int unsigned PC_W = 32, INSTR_W = 32, MEM_DEPTH = 256, FIFO_DEPTH = 4;
    localparam int unsigned AW = 8, CW = 3;
    localparam logic [31:0] I0 = 32'h20010001, I1 = 32'h20020002, I2 = 32'h20030003;
    localparam logic [31:0] HLT = 32'hFFFFFFFF, TGT = 32'hAAAA0000, TOP = 32'h11112222;

    logic               i_clk, i_reset, i_valid, i_wr_en, i_pc_src, i_stall;
    logic [AW-1:0]      i_wr_addr;
    logic [INSTR_W-1:0] i_wr_data;
    logic [PC_W-1:0]    i_pc_salto;
    logic [INSTR_W-1:0] o_instr;
    logic [PC_W-1:0]    o_pc_4, o_pc;
    logic               o_instr_valid, o_halt;
    logic [CW-1:0]      o_fifo_count;

    fetch_prefetch #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_DEPTH(MEM_DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH), .HALT_INSTR(32'hFFFFFFFF)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_wr_en(i_wr_en),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_pc_src(i_pc_src),
        .i_pc_salto(i_pc_salto), .i_stall(i_stall), .o_instr(o_instr),
        .o_pc_4(o_pc_4), .o_instr_valid(o_instr_valid), .o_halt(o_halt),
        .o_pc(o_pc), .o_fifo_count(o_fifo_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int unsigned n_vec = 0, n_err = 0;
    logic        sb_en = 1'b0;
    logic [63:0] sbq [$];

    typedef struct {
        logic        first;
        logic        valid;
        logic        stall;
        logic        exp_v;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic [2:0]  exp_cnt;
        logic        exp_halt;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 0; i_wr_en = 0; i_pc_src = 0; i_stall = 0;
        i_wr_addr = '0; i_wr_data = '0; i_pc_salto = '0;
        i_reset = 1;
        step();
        step();
        i_reset = 0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        i_valid = 0; i_wr_en = 1; i_wr_addr = a; i_wr_data = d;
        step();
        i_wr_en = 0;
    endtask

    task automatic load_prog();
        load(8'd0, I0); load(8'd1, I1); load(8'd2, I2); load(8'd3, HLT);
        load(8'd8, TGT); load(8'd9, HLT); load(8'd255, TOP);
    endtask

    task automatic wait_halt(input int unsigned max_cycles);
        for (int unsigned c = 0; c < max_cycles && !o_halt; c++) step();
        chk("halt_reached", {31'b0, o_halt}, 32'd1);
    endtask

    task automatic sb_drain(input string name);
        chk(name, sbq.size(), 32'd0);
        sbq.delete();
    endtask

    // Scoreboard consumer: every accepted head must match the next expected entry.
    always @(negedge i_clk) begin
        if (sb_en && !i_reset && o_instr_valid && !i_stall && !i_pc_src) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h/%h expected none", o_instr, o_pc_4);
            end else begin
                logic [63:0] e;
                e = sbq.pop_front();
                if ({o_instr, o_pc_4} !== e) begin
                    n_err++;
                    $display("FAIL sb_pop: got %h/%h expected %h/%h", o_instr, o_pc_4, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        // Free run, stalled fill then release, and i_valid dropped with a read in flight.
        tbl.push_back(vec_t'{1, 1, 0, 0, 32'h0, 32'h0,  3'd0, 0, 32'h4});
        tbl.push_back(vec_t'{0, 1, 0, 1, I0,    32'h4,  3'd1, 0, 32'h8});
        tbl.push_back(vec_t'{0, 1, 0, 1, I1,    32'h8,  3'd1, 0, 32'hC});
        tbl.push_back(vec_t'{0, 1, 0, 1, I2,    32'hC,  3'd1, 0, 32'h10});
        tbl.push_back(vec_t'{0, 1, 0, 0, HLT,   32'h10, 3'd1, 0, 32'h10});
        tbl.push_back(vec_t'{0, 1, 0, 0, 32'h0, 32'h0,  3'd0, 1, 32'h10});
        tbl.push_back(vec_t'{0, 1, 0, 0, 32'h0, 32'h0,  3'd0, 1, 32'h10});
        tbl.push_back(vec_t'{1, 1, 1, 0, 32'h0, 32'h0,  3'd0, 0, 32'h4});
        tbl.push_back(vec_t'{0, 1, 1, 1, I0,    32'h4,  3'd1, 0, 32'h8});
        tbl.push_back(vec_t'{0, 1, 1, 1, I0,    32'h4,  3'd2, 0, 32'hC});
        tbl.push_back(vec_t'{0, 1, 1, 1, I0,    32'h4,  3'd3, 0, 32'h10});
        tbl.push_back(vec_t'{0, 1, 1, 1, I0,    32'h4,  3'd4, 0, 32'h10});
        tbl.push_back(vec_t'{0, 1, 1, 1, I0,    32'h4,  3'd4, 0, 32'h10});
        tbl.push_back(vec_t'{0, 1, 0, 1, I1,    32'h8,  3'd3, 0, 32'h10});
        tbl.push_back(vec_t'{0, 1, 0, 1, I2,    32'hC,  3'd2, 0, 32'h10});
        tbl.push_back(vec_t'{0, 1, 0, 0, HLT,   32'h10, 3'd1, 0, 32'h10});
        tbl.push_back(vec_t'{0, 1, 0, 0, 32'h0, 32'h0,  3'd0, 1, 32'h10});
        tbl.push_back(vec_t'{1, 1, 0, 0, 32'h0, 32'h0,  3'd0, 0, 32'h4});
        tbl.push_back(vec_t'{0, 0, 0, 1, I0,    32'h4,  3'd1, 0, 32'h4});
        tbl.push_back(vec_t'{0, 0, 0, 0, 32'h0, 32'h0,  3'd0, 0, 32'h4});

        do_reset();
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_pc4", o_pc_4, 32'h0);
        chk("rst_flags", {29'b0, o_instr_valid, o_halt, 1'b0}, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_cnt", {29'b0, o_fifo_count}, 32'h0);

        foreach (tbl[k]) begin
            if (tbl[k].first) begin
                do_reset();
                load_prog();
            end
            i_valid = tbl[k].valid;
            i_stall = tbl[k].stall;
            step();
            chk($sformatf("r%0d_valid", k), {31'b0, o_instr_valid}, {31'b0, tbl[k].exp_v});
            chk($sformatf("r%0d_instr", k), o_instr, tbl[k].exp_instr);
            chk($sformatf("r%0d_pc4", k), o_pc_4, tbl[k].exp_pc4);
            chk($sformatf("r%0d_cnt", k), {29'b0, o_fifo_count}, {29'b0, tbl[k].exp_cnt});
            chk($sformatf("r%0d_halt", k), {31'b0, o_halt}, {31'b0, tbl[k].exp_halt});
            chk($sformatf("r%0d_pc", k), o_pc, tbl[k].exp_pc);
        end

        // Redirect while 20020002 is at the head: it and 20030003 are discarded.
        do_reset();
        load_prog();
        sb_en = 1;
        sbq.push_back({I0, 32'h4});
        sbq.push_back({TGT, 32'h24});
        i_valid = 1;
        step(); step(); step();
        chk("redir_head", o_instr, I1);
        i_pc_src = 1; i_pc_salto = 32'h20;
        step();
        i_pc_src = 0;
        chk("redir_cnt", {29'b0, o_fifo_count}, 32'h0);
        chk("redir_pc", o_pc, 32'h20);
        step();
        chk("redir_gap", {31'b0, o_instr_valid}, 32'h0);
        step();
        chk("redir_tgt", o_instr, TGT);
        chk("redir_tgt_pc4", o_pc_4, 32'h24);
        wait_halt(20);
        sb_drain("redir_drain");

        // Flush with the halt word queued: halt must not stick, fetch resumes at target.
        do_reset();
        load_prog();
        sbq.push_back({TGT, 32'h24});
        i_valid = 1; i_stall = 1;
        repeat (5) step();
        chk("fh_full", {29'b0, o_fifo_count}, 32'd4);
        i_pc_src = 1; i_pc_salto = 32'h20;
        step();
        i_pc_src = 0; i_stall = 0;
        chk("fh_halt0", {31'b0, o_halt}, 32'h0);
        chk("fh_cnt", {29'b0, o_fifo_count}, 32'h0);
        step(); step();
        chk("fh_tgt", o_instr, TGT);
        chk("fh_halt1", {31'b0, o_halt}, 32'h0);
        wait_halt(20);
        chk("fh_pc", o_pc, 32'h28);
        sb_drain("fh_drain");

        // Redirect near the top of the address space with unaligned low bits.
        do_reset();
        load_prog();
        i_pc_src = 1; i_pc_salto = 32'hFFFFFFFE;
        step();
        i_pc_src = 0;
        chk("wrap_pc", o_pc, 32'hFFFFFFFE);
        sbq.push_back({TOP, 32'h2});
        sbq.push_back({I0, 32'h6});
        sbq.push_back({I1, 32'hA});
        sbq.push_back({I2, 32'hE});
        i_valid = 1;
        wait_halt(20);
        chk("wrap_pc_end", o_pc, 32'h12);
        sb_drain("wrap_drain");
        sb_en = 0;

        // Program write while running must be ignored.
        do_reset();
        i_valid = 1; i_wr_en = 1; i_wr_addr = 8'd0; i_wr_data = 32'h12345678;
        step();
        i_wr_en = 0;
        step();
        chk("wguard", o_instr, I0);

        // Asynchronous reset in the middle of a cycle.
        do_reset();
        i_valid = 1; i_stall = 1;
        repeat (4) step();
        chk("ar_cnt", {29'b0, o_fifo_count}, 32'd3);
        #2;
        i_reset = 1;
        #1;
        chk("ar_instr", o_instr, 32'h0);
        chk("ar_pc4", o_pc_4, 32'h0);
        chk("ar_flags", {30'b0, o_instr_valid, o_halt}, 32'h0);
        chk("ar_pc", o_pc, 32'h0);
        chk("ar_cnt0", {29'b0, o_fifo_count}, 32'h0);
        i_reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
Parametrised instruction-fetch stage for the MIPS pipeline. It holds the fetch PC, a loadable instruction memory and a small prefetch FIFO that decouples fetch from decode stalls. It supports branch/jump redirect with flush, sticky halt detection, and program loading from the debug unit while not running. It sits between the debug unit / PC-redirect logic and the IF/ID boundary.

Parameters:
PC_W, 32, PC and PC+4 width (byte address)
INSTR_W, 32, instruction width
MEM_DEPTH, 256, instruction memory depth in words (power of 2); AW = clog2(MEM_DEPTH)
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
HALT_INSTR, 32'hFFFFFFFF, encoding that halts fetch

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  run enable from the debug unit; 0 = no new fetch requests
i_wr_en  in  1  program-load write strobe; honoured only when i_valid=0
i_wr_addr  in  AW  word address for the program load
i_wr_data  in  INSTR_W  program-load data
i_pc_src  in  1  redirect request (taken branch/jump)
i_pc_salto  in  PC_W  redirect target byte address
i_stall  in  1  decode not accepting; head is held
o_instr  out  INSTR_W  FIFO head instruction
o_pc_4  out  PC_W  FIFO head PC + 4
o_instr_valid  out  1  head is valid and not halted
o_halt  out  1  sticky; the halt instruction has been consumed
o_pc  out  PC_W  next fetch PC
o_fifo_count  out  clog2(FIFO_DEPTH+1)  occupied FIFO entries

Behaviour:
- Reset (async): fetch_pc=0, FIFO empty, inflight=0, halt_seen=0. o_instr=0, o_pc_4=0, o_instr_valid=0, o_halt=0, o_pc=0, o_fifo_count=0. Memory contents are not reset.
- Priority: reset > i_pc_src (flush) > pop/push.
- Request: issued in a cycle when i_valid=1, halt_seen=0, i_pc_src=0 and count+inflight < FIFO_DEPTH. The read address is fetch_pc[AW+1:2]. The read is synchronous. On a request, fetch_pc <= fetch_pc+4 (mod 2^PC_W), and inflight=1 for the next cycle.
- Response: one cycle after the request, {mem_data, req_pc+4} is pushed into the FIFO. It is visible at o_instr on the cycle after the push. Request-to-o_instr_valid latency is 2 cycles.
- Full: the request gate counts in-flight reads, so the FIFO never overflows. Push and pop in the same cycle leave count unchanged.
- Pop: occurs when o_instr_valid=1 and i_stall=0. o_instr and o_pc_4 show the new head the next cycle.
- i_stall=1: head, count and outputs are held. Prefetch continues until the FIFO is full.
- Halt: a response equal to HALT_INSTR sets halt_seen, and no further requests are issued. The halt word is pushed like any other instruction. When it reaches the head, o_instr_valid=0. On the next cycle with i_stall=0, it is popped and o_halt=1, which is sticky until reset.
- Redirect (i_pc_src=1 in cycle N): fetch_pc <= i_pc_salto, the FIFO is flushed (count=0), any in-flight response is discarded, and halt_seen is cleared unless o_halt=1. No pop or request happens in cycle N. Request in N+1; first target instruction valid in N+3. A redirect after o_halt=1 updates fetch_pc only.
- i_valid=0: no new requests. The in-flight read completes and pushes. Pops are still allowed.
- Program load: when i_wr_en=1 and i_valid=0, mem[i_wr_addr] <= i_wr_data. It is ignored when i_valid=1.
- Wrap-around: the memory index wraps mod MEM_DEPTH. o_pc_4 wraps mod 2^PC_W.
- Low bits of i_pc_salto[1:0] are ignored for addressing but kept in fetch_pc.

Test Plan:
- Reset/load: assert reset, load mem[0..3]=20010001,20020002,20030003,FFFFFFFF with i_valid=0, then set i_valid=1 -> o_instr_valid rises 2 cycles later; o_instr 20010001/o_pc_4 4, then 20020002/8, then 20030003/C on consecutive cycles. o_instr_valid drops at the halt word; o_halt=1 one cycle later; o_pc=10.
- Stall: hold i_stall=1 from first valid -> o_fifo_count reaches 4, o_pc stops at 10, o_instr stays 20010001. Release -> three instructions stream with no bubble.
- Redirect: in the cycle o_instr=20020002, i_pc_src=1, i_pc_salto=0x20 (mem[8]=AAAA0000) -> count=0 next cycle, 20030003 never appears, AAAA0000 with o_pc_4=24 valid 3 cycles after the redirect.
- Flush halt: redirect while the halt word is queued -> o_halt stays 0 and fetch resumes at target.
- Write guard: i_wr_en=1 with i_valid=1 to addr 0 with 12345678 -> mem[0] unchanged on refetch.
- Async reset mid-run with count=3 -> all outputs 0 immediately, before the clock edge.
